// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Used by regfile_wb_arbiter and wb_scoreboard.
package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(
        input logic [ADDR_W-1:0] idx
    );
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: reservation sets, writeback clears,
// set wins on collision, x0 never busy, two hazard query ports.
module wb_scoreboard
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_rd,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_rd,
    input  logic [ADDR_W-1:0]   query_rs1,
    input  logic [ADDR_W-1:0]   query_rs2,
    output logic                hazard_rs1,
    output logic                hazard_rs2,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: clear first, then apply the newer reservation.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && set_rd != '0) begin
            set_mask = reg_onehot(set_rd);
        end
        if (clr_en) begin
            clr_mask = reg_onehot(clr_rd);
        end
        busy_d = ((busy_q & ~clr_mask) | set_mask)
               & ~NUM_REGS'(1);
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A register written this cycle is forwarded upstream, so no hazard.
    always_comb begin
        hazard_rs1 = busy_q[query_rs1]
                   & ~(clr_en && clr_rd == query_rs1);
        hazard_rs2 = busy_q[query_rs2]
                   & ~(clr_en && clr_rd == query_rs2);
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Optional counters enabled by REGFILE_WB_STATS_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                req_a_valid_i,
    input  logic [ADDR_W-1:0]   req_a_rd_i,
    input  logic [XLEN-1:0]     req_a_data_i,
    output logic                req_a_ready_o,
    input  logic                req_b_valid_i,
    input  logic [ADDR_W-1:0]   req_b_rd_i,
    input  logic [XLEN-1:0]     req_b_data_i,
    output logic                req_b_ready_o,
    input  logic                rsv_valid_i,
    input  logic [ADDR_W-1:0]   rsv_rd_i,
    input  logic [ADDR_W-1:0]   query_rs1_i,
    input  logic [ADDR_W-1:0]   query_rs2_i,
    output logic                hazard_rs1_o,
    output logic                hazard_rs2_o,
    output logic [NUM_REGS-1:0] busy_o,
`ifdef REGFILE_WB_STATS_EN
    output logic [15:0]         stat_conflicts_o,
    output logic [15:0]         stat_x0_drops_o,
`endif
    output logic                Reg_Write_o,
    output logic [ADDR_W-1:0]   Write_Register_o,
    output logic [XLEN-1:0]     Write_Data_o
);

    req_id_e last_grant;
    logic    grant_a;
    logic    grant_b;
    logic    accept;
    logic    write_x0;
    wb_req_t sel_req;

    // Round-robin grant: a lone requester wins, on conflict the
    // requester that was not granted last wins.
    always_comb begin
        grant_a = req_a_valid_i
                & (~req_b_valid_i | (last_grant == REQ_B));
        grant_b = req_b_valid_i
                & (~req_a_valid_i | (last_grant == REQ_A));
        accept  = grant_a | grant_b;
        sel_req.rd   = grant_a ? req_a_rd_i : req_b_rd_i;
        sel_req.data = grant_a ? req_a_data_i : req_b_data_i;
        write_x0 = accept && sel_req.rd == '0;
    end

    assign req_a_ready_o = grant_a;
    assign req_b_ready_o = grant_b;

    // Output stage and round-robin pointer; x0 writes are swallowed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant       <= REQ_B;
            Reg_Write_o      <= 1'b0;
            Write_Register_o <= '0;
            Write_Data_o     <= '0;
        end else begin
            Reg_Write_o <= accept && !write_x0;
            if (accept) begin
                last_grant <= grant_a ? REQ_A : REQ_B;
            end
            if (accept && !write_x0) begin
                Write_Register_o <= sel_req.rd;
                Write_Data_o     <= sel_req.data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en     (rsv_valid_i),
        .set_rd     (rsv_rd_i),
        .clr_en     (Reg_Write_o),
        .clr_rd     (Write_Register_o),
        .query_rs1  (query_rs1_i),
        .query_rs2  (query_rs2_i),
        .hazard_rs1 (hazard_rs1_o),
        .hazard_rs2 (hazard_rs2_o),
        .busy       (busy_o)
    );

`ifdef REGFILE_WB_STATS_EN
    // Saturating conflict and x0-drop counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_conflicts_o <= '0;
            stat_x0_drops_o  <= '0;
        end else begin
            if (req_a_valid_i && req_b_valid_i
                && stat_conflicts_o != 16'hFFFF) begin
                stat_conflicts_o <= stat_conflicts_o + 16'd1;
            end
            if (write_x0 && stat_x0_drops_o != 16'hFFFF) begin
                stat_x0_drops_o <= stat_x0_drops_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Stats checks compile in when REGFILE_WB_STATS_EN is defined.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_rd;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        hz1;
    logic        hz2;
    logic [31:0] busy;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
`ifdef REGFILE_WB_STATS_EN
    logic [15:0] st_conf;
    logic [15:0] st_x0;
`endif

    int vectors = 0;
    int errors  = 0;

    regfile_wb_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .req_a_valid_i    (a_valid),
        .req_a_rd_i       (a_rd),
        .req_a_data_i     (a_data),
        .req_a_ready_o    (a_ready),
        .req_b_valid_i    (b_valid),
        .req_b_rd_i       (b_rd),
        .req_b_data_i     (b_data),
        .req_b_ready_o    (b_ready),
        .rsv_valid_i      (rsv_valid),
        .rsv_rd_i         (rsv_rd),
        .query_rs1_i      (q1),
        .query_rs2_i      (q2),
        .hazard_rs1_o     (hz1),
        .hazard_rs2_o     (hz2),
        .busy_o           (busy),
`ifdef REGFILE_WB_STATS_EN
        .stat_conflicts_o (st_conf),
        .stat_x0_drops_o  (st_x0),
`endif
        .Reg_Write_o      (wr_en),
        .Write_Register_o (wr_idx),
        .Write_Data_o     (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        a_valid   = 1'b0;
        a_rd      = '0;
        a_data    = '0;
        b_valid   = 1'b0;
        b_rd      = '0;
        b_data    = '0;
        rsv_valid = 1'b0;
        rsv_rd    = '0;
        q1        = '0;
        q2        = '0;

        // Reset state
        tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_idx", 32'(wr_idx), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        #4 reset = 1'b1;

        // Single A write to x5
        tick();
        a_valid = 1'b1;
        a_rd    = 5'd5;
        a_data  = 32'hDEADBEEF;
        #1;
        chk("t1_a_ready", 32'(a_ready), 32'd1);
        chk("t1_b_ready", 32'(b_ready), 32'd0);
        tick();
        a_valid = 1'b0;
        chk("t1_wr_en", 32'(wr_en), 32'd1);
        chk("t1_wr_idx", 32'(wr_idx), 32'd5);
        chk("t1_wr_data", wr_data, 32'hDEADBEEF);
        tick();
        chk("t1_wr_en_off", 32'(wr_en), 32'd0);
        chk("t1_idx_hold", 32'(wr_idx), 32'd5);
        chk("t1_data_hold", wr_data, 32'hDEADBEEF);

        // B write to x0: accepted, dropped
        b_valid = 1'b1;
        b_rd    = 5'd0;
        b_data  = 32'h1234;
        #1;
        chk("x0_b_ready", 32'(b_ready), 32'd1);
        tick();
        b_valid = 1'b0;
        chk("x0_wr_en", 32'(wr_en), 32'd0);
        chk("x0_idx_hold", 32'(wr_idx), 32'd5);

        // Conflict held 4 cycles: last grant is B, so A,B,A,B
        a_valid = 1'b1;
        a_rd    = 5'd1;
        a_data  = 32'h11;
        b_valid = 1'b1;
        b_rd    = 5'd2;
        b_data  = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_a_ready", 32'(a_ready),
                (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_b_ready", 32'(b_ready),
                (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("rr_wr_en", 32'(wr_en), 32'd1);
            chk("rr_wr_idx", 32'(wr_idx),
                (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_wr_data", wr_data,
                (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        chk("rr_wr_en_off", 32'(wr_en), 32'd0);
`ifdef REGFILE_WB_STATS_EN
        chk("st_conflicts", 32'(st_conf), 32'd4);
        chk("st_x0_drops", 32'(st_x0), 32'd1);
`endif

        // Reserve x7, hazard next cycle, cleared by its write
        rsv_valid = 1'b1;
        rsv_rd    = 5'd7;
        q1        = 5'd7;
        q2        = 5'd0;
        #1;
        chk("h7_before", 32'(hz1), 32'd0);
        tick();
        rsv_valid = 1'b0;
        chk("h7_hazard", 32'(hz1), 32'd1);
        chk("h7_busy", busy, 32'h0000_0080);
        chk("h0_hazard", 32'(hz2), 32'd0);
        a_valid = 1'b1;
        a_rd    = 5'd7;
        a_data  = 32'h77;
        #1;
        chk("h7_a_ready", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        chk("h7_wr_en", 32'(wr_en), 32'd1);
        chk("h7_wr_idx", 32'(wr_idx), 32'd7);
        chk("h7_fwd_hz", 32'(hz1), 32'd0);
        chk("h7_busy_wr", busy, 32'h0000_0080);
        tick();
        chk("h7_busy_clr", busy, 32'd0);
        chk("h7_hz_clr", 32'(hz1), 32'd0);

        // x0 reservation never sets busy
        rsv_valid = 1'b1;
        rsv_rd    = 5'd0;
        tick();
        chk("rsv_x0", busy, 32'd0);

        // Set and clear of x9 in the same cycle: set wins
        rsv_rd  = 5'd9;
        a_valid = 1'b1;
        a_rd    = 5'd9;
        a_data  = 32'h99;
        tick();
        a_valid = 1'b0;
        chk("waw_wr_idx", 32'(wr_idx), 32'd9);
        chk("waw_busy_pre", busy, 32'h0000_0200);
        q2 = 5'd9;
        #1;
        chk("waw_fwd_hz2", 32'(hz2), 32'd0);
        tick();
        chk("waw_busy", busy, 32'h0000_0200);
        chk("waw_hz2", 32'(hz2), 32'd1);

        // Reserve x7 while writing x3, then async reset
        rsv_rd  = 5'd7;
        a_valid = 1'b1;
        a_rd    = 5'd3;
        a_data  = 32'h33;
        tick();
        rsv_valid = 1'b0;
        a_valid   = 1'b0;
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        chk("pre_rst_busy", busy, 32'h0000_0280);
        #2 reset = 1'b0;
        #1;
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_wr_idx", 32'(wr_idx), 32'd0);
        chk("arst_wr_data", wr_data, 32'd0);
        chk("arst_busy", busy, 32'd0);
`ifdef REGFILE_WB_STATS_EN
        chk("arst_st_conf", 32'(st_conf), 32'd0);
        chk("arst_st_x0", 32'(st_x0), 32'd0);
`endif
        #3 reset = 1'b1;

        // After reset the first conflict goes to A
        tick();
        a_valid = 1'b1;
        a_rd    = 5'd4;
        a_data  = 32'h44;
        b_valid = 1'b1;
        b_rd    = 5'd6;
        b_data  = 32'h66;
        #1;
        chk("post_rst_a_ready", 32'(a_ready), 32'd1);
        chk("post_rst_b_ready", 32'(b_ready), 32'd0);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("post_rst_wr_idx", 32'(wr_idx), 32'd4);
        chk("post_rst_wr_data", wr_data, 32'h44);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters:
  - A: ALU/immediate path.
  - B: load/memory path.
- Uses round-robin arbitration and a one-cycle registered output stage that drives the register file write port.
- Keeps a 32-bit pending-write scoreboard. The issue stage reserves a destination; the write retires it. Two read-operand hazard queries are answered combinationally.
- Sits between the execute/memory stages and the register file.

Parameters:
- XLEN, 32, data width of write data.
- NUM_REGS, 32, number of architectural registers (x0 hard-wired zero).
- ADDR_W, 5, register index width (log2 NUM_REGS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_a_valid_i  in  1  requester A has a write pending.
- req_a_rd_i  in  ADDR_W  A destination register.
- req_a_data_i  in  XLEN  A write data.
- req_a_ready_o  out  1  A accepted this cycle.
- req_b_valid_i / req_b_rd_i / req_b_data_i / req_b_ready_o  same widths and meaning, requester B.
- rsv_valid_i  in  1  issue stage reserves a destination.
- rsv_rd_i  in  ADDR_W  register being reserved.
- query_rs1_i  in  ADDR_W  operand 1 index.
- query_rs2_i  in  ADDR_W  operand 2 index.
- hazard_rs1_o  out  1  operand 1 has a pending write.
- hazard_rs2_o  out  1  operand 2 has a pending write.
- busy_o  out  NUM_REGS  scoreboard vector.
- Reg_Write_o  out  1  register file write enable.
- Write_Register_o  out  ADDR_W  register file write index.
- Write_Data_o  out  XLEN  register file write data.

Behaviour:
- Reset (reset=0, asynchronous): all of the following clear; any in-flight write is discarded:
  - Reg_Write_o=0, Write_Register_o=0, Write_Data_o=0.
  - busy_o=0.
  - Round-robin pointer last_grant=B, so A wins the first conflict.
- Handshake:
  - Transfer occurs when valid & ready.
  - A requester holds valid, rd and data stable until it is accepted.
  - ready is combinational from both valids and last_grant; it never depends on that requester's own data.
- Arbitration: at most one accept per cycle.
  - Only one requester valid: it is granted.
  - Both valid: the requester other than last_grant is granted.
  - last_grant updates on every accept.
  - Worst-case wait for a held request is 1 cycle.
- Output stage, cycle after an accept:
  - Reg_Write_o=1, Write_Register_o=rd, Write_Data_o=data.
  - With no accept: Reg_Write_o=0; index and data hold their last values.
  - Latency from accept to register file write edge: 1 clock.
- x0 writes: a request with rd=0 is accepted (ready=1) but dropped; Reg_Write_o stays 0 the following cycle.
- Scoreboard:
  - Set: rsv_valid_i & rsv_rd_i!=0 sets busy[rsv_rd_i] at the clock edge.
  - Clear: a cycle with Reg_Write_o=1 clears busy[Write_Register_o] at that edge.
  - Same register set and cleared in the same cycle: set wins (newer reservation, WAW).
  - Reserving an already-busy register leaves the bit at 1.
  - busy[0] is constant 0.
- Hazard query: hazard_rsN_o = busy[query_rsN_i] & ~(Reg_Write_o & Write_Register_o==query_rsN_i).
  - A register being written this cycle reports no hazard, because register file write-then-read is resolved by forwarding upstream.
  - hazard for index 0 is always 0.
- The arbiter does not check that a write was reserved. An unreserved write clears nothing extra (bit already 0).

Optional Feature:
- Macro: REGFILE_WB_STATS_EN.
- Defined: adds output stat_conflicts_o (16 bits) and output stat_x0_drops_o (16 bits).
  - stat_conflicts_o counts cycles with both valids high.
  - stat_x0_drops_o counts accepted rd=0 requests.
  - Both saturate at 0xFFFF and clear on reset.
- Not defined: ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package regfile_pkg:
  - Constants XLEN=32, NUM_REGS=32, ADDR_W=5.
  - Requester id enum {REQ_A=0, REQ_B=1}.
  - Typedef for a write request struct {rd, data}.
- One sub-module, wb_scoreboard: the busy vector with set/clear priority and two query ports. The top level holds arbitration, the output stage and the stats counters.

Test Plan:
- Reset release, then A valid rd=5 data=0xDEADBEEF alone -> req_a_ready_o=1 that cycle; next cycle Reg_Write_o=1, Write_Register_o=5, Write_Data_o=0xDEADBEEF; cycle after, Reg_Write_o=0.
- A and B both valid and held for 4 cycles (A rd=1, B rd=2) -> grants A,B,A,B; Reg_Write_o indices 1,2,1,2 each one cycle later.
- B valid rd=0 data=0x1234 -> req_b_ready_o=1, Reg_Write_o stays 0. With REGFILE_WB_STATS_EN, stat_x0_drops_o increments to 1.
- rsv rd=7, query_rs1=7 -> hazard_rs1_o=1 from the next cycle. Then write rd=7 accepted: hazard_rs1_o=0 in the Reg_Write_o cycle, and busy_o[7]=0 after it.
- Same cycle: rsv rd=9 and Reg_Write_o with Write_Register_o=9 -> busy_o[9]=1 afterwards.
- reset asserted while Reg_Write_o=1 and busy_o=0x0000_0280 -> outputs 0 immediately (asynchronous). After release, the first conflict grants A.
